// File: rtl/key_filter_if.sv
// Button input and debounced outputs of key_filter; key_long exists only
// when KEY_LONG_PRESS_EN is defined.
interface key_filter_if;
  logic key_in;
  logic key_flag;
  logic key_state;
`ifdef KEY_LONG_PRESS_EN
  logic key_long;

  modport master (output key_in, input key_flag, input key_state, input key_long);
  modport slave  (input key_in, output key_flag, output key_state, output key_long);
`else
  modport master (output key_in, input key_flag, input key_state);
  modport slave  (input key_in, output key_flag, output key_state);
`endif
endinterface

// File: rtl/key_filter.sv
// Debouncer for one active-low push-button: 2-flop synchroniser, 4-state
// filter FSM and stable-time counter. KEY_LONG_PRESS_EN adds a long-press pulse.
module key_filter #(
  parameter logic [31:0] CNT_MAX = 32'd999_999
`ifdef KEY_LONG_PRESS_EN
  , parameter logic [31:0] LONG_MAX = 32'd49_999_999
`endif
) (
  input logic          clk,
  input logic          rst_n,
  key_filter_if.slave  kif
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] FILTER_DN = 2'd1;
  localparam logic [1:0] DOWN      = 2'd2;
  localparam logic [1:0] FILTER_UP = 2'd3;

  logic        key_ff1;
  logic        key_sync;
  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] cnt;
  logic        cnt_done;
  logic        press_accept;
  logic        release_accept;
  logic        key_flag_q;
  logic        key_state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_ff1  <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_ff1  <= kif.key_in;
      key_sync <= key_ff1;
    end
  end

  assign cnt_done = (cnt == CNT_MAX);

  // Any bounce during a filter state drops back, so the count restarts from zero.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!key_sync) state_nxt = FILTER_DN;
      FILTER_DN: if (key_sync) state_nxt = IDLE;
                 else if (cnt_done) state_nxt = DOWN;
      DOWN:      if (key_sync) state_nxt = FILTER_UP;
      FILTER_UP: if (!key_sync) state_nxt = DOWN;
                 else if (cnt_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign press_accept   = (state == FILTER_DN) && (state_nxt == DOWN);
  assign release_accept = (state == FILTER_UP) && (state_nxt == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= 32'd0;
      else if ((state == FILTER_DN) || (state == FILTER_UP))
        cnt <= cnt + 32'd1;
      else
        cnt <= 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_flag_q  <= 1'b0;
      key_state_q <= 1'b1;
    end else begin
      key_flag_q <= press_accept;
      if (press_accept)
        key_state_q <= 1'b0;
      else if (release_accept)
        key_state_q <= 1'b1;
    end
  end

  assign kif.key_flag  = key_flag_q;
  assign kif.key_state = key_state_q;

`ifdef KEY_LONG_PRESS_EN
  logic [31:0] long_cnt;
  logic        long_done;
  logic        key_long_q;

  // Timer restarts only on a newly accepted press, so a release bounce
  // (FILTER_UP back to DOWN) cannot produce a second pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_cnt   <= 32'd0;
      long_done  <= 1'b0;
      key_long_q <= 1'b0;
    end else begin
      key_long_q <= 1'b0;
      if (press_accept) begin
        long_cnt  <= 32'd0;
        long_done <= 1'b0;
      end else if ((state == DOWN) || (state == FILTER_UP)) begin
        if (long_cnt != LONG_MAX)
          long_cnt <= long_cnt + 32'd1;
        else begin
          long_done  <= 1'b1;
          key_long_q <= !long_done;
        end
      end else begin
        long_cnt  <= 32'd0;
        long_done <= 1'b0;
      end
    end
  end

  assign kif.key_long = key_long_q;
`endif

endmodule
